bank_reg_ctrl: RTL and testbench
================================

# bank_reg_ctrl

Owns the erasable-bank, fixed-bank, both-bank and superbank registers, and drives the `eBank`/`fBank`/`superBank` inputs of the address mapper. CPU register-file accesses to bank addresses are staged in shadow registers. They reach the mapper only at an instruction boundary, so an in-flight fetch always sees a stable bank. A one-deep save slot preserves the live bank selection across interrupt entry and resume.

## Interface
- No parameters.
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `wrEn` in 1: register write request.
- `rdEn` in 1: register read request.
- `regAddr` in 12: register address; EB=12'd3, FB=12'd4, BB=12'd6.
- `wrData` in 16: write data.
- `rdData` out 16: read data, valid while `ack` is high.
- `ack` out 1: request acknowledge.
- `chanWrEn` in 1: I/O channel 7 write strobe.
- `chanWrData` in 16: channel 7 data; bit 6 is superbank.
- `commit` in 1: instruction-boundary pulse.
- `intEntry` in 1: interrupt entry pulse.
- `intResume` in 1: interrupt resume pulse.
- `eBank` out 3: committed erasable bank.
- `fBank` out 5: committed fixed bank.
- `superBank` out 1: committed superbank bit.
- `pending` out 1: staged differs from committed.

## Operation
- State: staged `{sEb, sFb, sSb}`, committed `{eBank, fBank, superBank}`, save slot `{vEb, vFb, vSb}`.
- Register word formats:
  - EB: `eb` in bits 10:8, other bits 0.
  - FB: `fb` in bits 15:11, other bits 0.
  - BB: `fb` in bits 15:11, `eb` in bits 2:0, other bits 0.
- Writes:
  - EB write sets `sEb`.
  - FB write sets `sFb`.
  - BB write sets both `sFb` and `sEb`.
  - Unused word bits are ignored.
  - Writes to any other `regAddr` are ignored but still acked.
- Reads:
  - Reads return staged values in the formats above.
  - Reads of any other address return 16'h0000.
- If `wrEn` and `rdEn` are both high, the request is a write, and `rdData` returns the pre-write staged value of that address.
- `chanWrEn` sets `sSb` from `chanWrData[6]`. It produces no ack.
- `commit`: committed ← staged. A write or `chanWrEn` in the same cycle is included, so the committed value equals the new staged value.
- `intEntry`: save slot ← committed. Staged and committed are unchanged.
- `intResume`: staged and committed ← save slot. This overrides a same-cycle write, `chanWrEn` or `commit`.
- `intEntry` and `intResume` in the same cycle: only `intResume` acts; the save slot is unchanged.
- `pending` = (`{sEb, sFb, sSb}` ≠ `{eBank, fBank, superBank}`), registered.

## Timing
- Reset value of every register and output is 0: `rdData`, `ack`, `eBank`, `fBank`, `superBank`, `pending`, staged registers, save slot.
- Reset is asynchronous; any request, commit or interrupt in flight is discarded.
- A request sampled at edge N gives `ack`=1 and valid `rdData` for the cycle after edge N (latency 1).
- Back-to-back requests are accepted every cycle; there is no busy state.
- `ack` is 0 and `rdData` is 16'h0000 in cycles with no request.
- Committed outputs update at the edge that samples `commit` or `intResume`.
- A read acked in the same cycle as a commit returns the staged value, not the committed value.
- `pending` reflects state after the same edge.

## Configuration
- `BANKREG_SUPERBANK_EN` defined: superbank path implemented as described.
- Not defined:
  - `sSb`, `superBank` and `vSb` are constant 0.
  - `chanWrEn` and `chanWrData` are ignored.
  - `pending` compares eb/fb only.

## Test plan
- Reset, then write EB with 16'h0500 → next cycle `ack`=1. `eBank` stays 0 and `pending`=1. After a `commit` pulse, `eBank`=5 and `pending`=0.
- Write BB with 16'hF807, then commit → `fBank`=31, `eBank`=7. A read of FB returns 16'hF800; a read of BB returns 16'hF807.
- `wrEn`+`commit` in the same cycle, FB with 16'h2800 → `fBank`=5 on that edge. Read of address 12'd5 → `ack`=1, `rdData`=16'h0000.
- With the macro defined: `chanWrEn` with 16'h0040, then commit → `superBank`=1. Without the macro → `superBank` stays 0.
- Committed eb=2, fb=9, then `intEntry`. Write and commit eb=4, fb=1. Then `intResume` together with a write of FB 16'h0800 → `eBank`=2, `fBank`=9, `pending`=0.
- Assert `rst_n` low mid-burst after staging fb=3 → all outputs 0 immediately. After release, a read of FB returns 16'h0000.

Source files
------------

// File: rtl/bank_reg_ctrl_if.sv
// CPU register-file, channel 7 and interrupt signals of the bank register controller,
// plus the committed bank outputs that feed the address mapper.
interface bank_reg_ctrl_if;
  logic        wrEn;
  logic        rdEn;
  logic [11:0] regAddr;
  logic [15:0] wrData;
  logic [15:0] rdData;
  logic        ack;
  logic        chanWrEn;
  logic [15:0] chanWrData;
  logic        commit;
  logic        intEntry;
  logic        intResume;
  logic [2:0]  eBank;
  logic [4:0]  fBank;
  logic        superBank;
  logic        pending;

  modport master (
    output wrEn, rdEn, regAddr, wrData, chanWrEn, chanWrData,
           commit, intEntry, intResume,
    input  rdData, ack, eBank, fBank, superBank, pending
  );

  modport slave (
    input  wrEn, rdEn, regAddr, wrData, chanWrEn, chanWrData,
           commit, intEntry, intResume,
    output rdData, ack, eBank, fBank, superBank, pending
  );
endinterface

// File: rtl/bank_reg_ctrl.sv
// Staged/committed/saved bank registers for the address mapper; superbank path under BANKREG_SUPERBANK_EN.
// Register ack and read data one cycle after the request; a request is accepted every cycle, never stalled.
module bank_reg_ctrl (
  input  logic           clk,
  input  logic           rst_n,
  bank_reg_ctrl_if.slave bus
);

  localparam logic [11:0] ADDR_EB = 12'd3;
  localparam logic [11:0] ADDR_FB = 12'd4;
  localparam logic [11:0] ADDR_BB = 12'd6;

  logic [2:0]  s_eb_q, s_eb_d;
  logic [4:0]  s_fb_q, s_fb_d;
  logic [2:0]  c_eb_q, c_eb_d;
  logic [4:0]  c_fb_q, c_fb_d;
  logic [2:0]  v_eb_q, v_eb_d;
  logic [4:0]  v_fb_q, v_fb_d;
  logic [15:0] rd_data_q, rd_data_d;
  logic        ack_q, ack_d;
  logic        pending_q, pending_d;
  logic [15:0] rd_word;
  logic        req;
  logic        unused_wr;

  assign req       = bus.wrEn | bus.rdEn;
  assign unused_wr = ^bus.wrData[7:3];

  // Reads always see the staged values as they stood before this edge.
  always_comb begin
    rd_word = 16'h0000;
    case (bus.regAddr)
      ADDR_EB: rd_word = {5'b0, s_eb_q, 8'b0};
      ADDR_FB: rd_word = {s_fb_q, 11'b0};
      ADDR_BB: rd_word = {s_fb_q, 8'b0, s_eb_q};
      default: rd_word = 16'h0000;
    endcase
  end

  always_comb begin
    s_eb_d    = s_eb_q;
    s_fb_d    = s_fb_q;
    c_eb_d    = c_eb_q;
    c_fb_d    = c_fb_q;
    v_eb_d    = v_eb_q;
    v_fb_d    = v_fb_q;
    ack_d     = req;
    rd_data_d = req ? rd_word : 16'h0000;

    if (bus.wrEn) begin
      case (bus.regAddr)
        ADDR_EB: s_eb_d = bus.wrData[10:8];
        ADDR_FB: s_fb_d = bus.wrData[15:11];
        ADDR_BB: begin
          s_fb_d = bus.wrData[15:11];
          s_eb_d = bus.wrData[2:0];
        end
        default: ;
      endcase
    end

    if (bus.commit) begin
      c_eb_d = s_eb_d;
      c_fb_d = s_fb_d;
    end

    // Resume wins over everything else arriving on the same edge, including entry.
    if (bus.intResume) begin
      s_eb_d = v_eb_q;
      s_fb_d = v_fb_q;
      c_eb_d = v_eb_q;
      c_fb_d = v_fb_q;
    end else if (bus.intEntry) begin
      v_eb_d = c_eb_q;
      v_fb_d = c_fb_q;
    end
  end

`ifdef BANKREG_SUPERBANK_EN
  logic s_sb_q, s_sb_d;
  logic c_sb_q, c_sb_d;
  logic v_sb_q, v_sb_d;
  logic unused_chan;

  assign unused_chan = ^{bus.chanWrData[15:7], bus.chanWrData[5:0]};

  always_comb begin
    s_sb_d = s_sb_q;
    c_sb_d = c_sb_q;
    v_sb_d = v_sb_q;
    if (bus.chanWrEn) begin
      s_sb_d = bus.chanWrData[6];
    end
    if (bus.commit) begin
      c_sb_d = s_sb_d;
    end
    if (bus.intResume) begin
      s_sb_d = v_sb_q;
      c_sb_d = v_sb_q;
    end else if (bus.intEntry) begin
      v_sb_d = c_sb_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_sb_q <= 1'b0;
      c_sb_q <= 1'b0;
      v_sb_q <= 1'b0;
    end else begin
      s_sb_q <= s_sb_d;
      c_sb_q <= c_sb_d;
      v_sb_q <= v_sb_d;
    end
  end
`else
  logic s_sb_d;
  logic c_sb_d;
  logic c_sb_q;
  logic unused_chan;

  assign s_sb_d      = 1'b0;
  assign c_sb_d      = 1'b0;
  assign c_sb_q      = 1'b0;
  assign unused_chan = ^{bus.chanWrEn, bus.chanWrData};
`endif

  assign pending_d = ({s_eb_d, s_fb_d, s_sb_d} != {c_eb_d, c_fb_d, c_sb_d});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_eb_q    <= 3'd0;
      s_fb_q    <= 5'd0;
      c_eb_q    <= 3'd0;
      c_fb_q    <= 5'd0;
      v_eb_q    <= 3'd0;
      v_fb_q    <= 5'd0;
      rd_data_q <= 16'h0000;
      ack_q     <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      s_eb_q    <= s_eb_d;
      s_fb_q    <= s_fb_d;
      c_eb_q    <= c_eb_d;
      c_fb_q    <= c_fb_d;
      v_eb_q    <= v_eb_d;
      v_fb_q    <= v_fb_d;
      rd_data_q <= rd_data_d;
      ack_q     <= ack_d;
      pending_q <= pending_d;
    end
  end

  assign bus.rdData    = rd_data_q;
  assign bus.ack       = ack_q;
  assign bus.eBank     = c_eb_q;
  assign bus.fBank     = c_fb_q;
  assign bus.superBank = c_sb_q;
  assign bus.pending   = pending_q;

endmodule

// File: tb/tb_bank_reg_ctrl.sv
// Bench for bank_reg_ctrl: directed scenarios with literal expectations, then random traffic
// checked every cycle against a behavioural model of the bank registers.
module tb_bank_reg_ctrl;

  logic clk;
  logic rst_n;
  bank_reg_ctrl_if bif ();

  bank_reg_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Behavioural model: staged, committed and saved selections as plain integers.
  int m_seb = 0, m_sfb = 0, m_ssb = 0;
  int m_ceb = 0, m_cfb = 0, m_csb = 0;
  int m_veb = 0, m_vfb = 0, m_vsb = 0;
  int exp_rd = 0, exp_ack = 0, exp_pend = 0;
  int sb_on;

  initial begin
`ifdef BANKREG_SUPERBANK_EN
    sb_on = 1;
`else
    sb_on = 0;
`endif
  end

  function automatic int word_of(input int addr, input int eb, input int fb);
    case (addr)
      3:       return eb * 256;
      4:       return fb * 2048;
      6:       return fb * 2048 + eb;
      default: return 0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_seb = 0; m_sfb = 0; m_ssb = 0;
      m_ceb = 0; m_cfb = 0; m_csb = 0;
      m_veb = 0; m_vfb = 0; m_vsb = 0;
      exp_rd = 0; exp_ack = 0; exp_pend = 0;
    end else begin
      exp_ack = (bif.wrEn || bif.rdEn) ? 1 : 0;
      exp_rd  = exp_ack ? word_of(int'(bif.regAddr), m_seb, m_sfb) : 0;
      if (bif.wrEn) begin
        if (bif.regAddr == 12'd3) m_seb = (int'(bif.wrData) / 256) % 8;
        if (bif.regAddr == 12'd4) m_sfb = int'(bif.wrData) / 2048;
        if (bif.regAddr == 12'd6) begin
          m_sfb = int'(bif.wrData) / 2048;
          m_seb = int'(bif.wrData) % 8;
        end
      end
      if (sb_on == 1 && bif.chanWrEn) m_ssb = (int'(bif.chanWrData) / 64) % 2;
      if (bif.intResume) begin
        m_seb = m_veb; m_sfb = m_vfb; m_ssb = m_vsb;
        m_ceb = m_veb; m_cfb = m_vfb; m_csb = m_vsb;
      end else begin
        if (bif.intEntry) begin
          m_veb = m_ceb; m_vfb = m_cfb; m_vsb = m_csb;
        end
        if (bif.commit) begin
          m_ceb = m_seb; m_cfb = m_sfb; m_csb = m_ssb;
        end
      end
      exp_pend = (m_seb != m_ceb || m_sfb != m_cfb || m_ssb != m_csb) ? 1 : 0;
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("model_ack",     16'(bif.ack),       16'(exp_ack));
      check("model_rdData",  bif.rdData,         16'(exp_rd));
      check("model_eBank",   16'(bif.eBank),     16'(m_ceb));
      check("model_fBank",   16'(bif.fBank),     16'(m_cfb));
      check("model_superBank", 16'(bif.superBank), 16'(m_csb));
      check("model_pending", 16'(bif.pending),   16'(exp_pend));
    end
  end

  task automatic drive_idle();
    bif.wrEn = 0; bif.rdEn = 0; bif.regAddr = 12'd0; bif.wrData = 16'h0;
    bif.chanWrEn = 0; bif.chanWrData = 16'h0;
    bif.commit = 0; bif.intEntry = 0; bif.intResume = 0;
  endtask

  // One cycle: drive at negedge, return just after the sampling edge.
  task automatic cyc(input bit wr, input bit rd, input logic [11:0] addr, input logic [15:0] d,
                     input bit chw, input logic [15:0] chd, input bit cm, input bit ie, input bit ir);
    @(negedge clk);
    bif.wrEn = wr; bif.rdEn = rd; bif.regAddr = addr; bif.wrData = d;
    bif.chanWrEn = chw; bif.chanWrData = chd;
    bif.commit = cm; bif.intEntry = ie; bif.intResume = ir;
    @(posedge clk);
    #2;
  endtask

  task automatic idle_cyc();
    cyc(0, 0, 12'd0, 16'h0, 0, 16'h0, 0, 0, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    drive_idle();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_ack",     16'(bif.ack),       16'h0);
    check("rst_rdData",  bif.rdData,         16'h0);
    check("rst_eBank",   16'(bif.eBank),     16'h0);
    check("rst_fBank",   16'(bif.fBank),     16'h0);
    check("rst_super",   16'(bif.superBank), 16'h0);
    check("rst_pending", 16'(bif.pending),   16'h0);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    cyc(1, 0, 12'd3, 16'h0500, 0, 16'h0, 0, 0, 0);
    check("eb_wr_ack",     16'(bif.ack),     16'h1);
    check("eb_wr_eBank",   16'(bif.eBank),   16'h0);
    check("eb_wr_pending", 16'(bif.pending), 16'h1);
    cyc(0, 0, 12'd0, 16'h0, 0, 16'h0, 1, 0, 0);
    check("eb_cm_eBank",   16'(bif.eBank),   16'h5);
    check("eb_cm_pending", 16'(bif.pending), 16'h0);
    check("eb_cm_ack",     16'(bif.ack),     16'h0);

    cyc(1, 0, 12'd6, 16'hF807, 0, 16'h0, 0, 0, 0);
    cyc(0, 0, 12'd0, 16'h0, 0, 16'h0, 1, 0, 0);
    check("bb_fBank", 16'(bif.fBank), 16'd31);
    check("bb_eBank", 16'(bif.eBank), 16'd7);
    cyc(0, 1, 12'd4, 16'h0, 0, 16'h0, 0, 0, 0);
    check("rd_fb", bif.rdData, 16'hF800);
    cyc(0, 1, 12'd6, 16'h0, 0, 16'h0, 0, 0, 0);
    check("rd_bb", bif.rdData, 16'hF807);
    cyc(0, 1, 12'd3, 16'h0, 0, 16'h0, 0, 0, 0);
    check("rd_eb", bif.rdData, 16'h0700);

    cyc(1, 0, 12'd4, 16'h2800, 0, 16'h0, 1, 0, 0);
    check("wrcm_fBank",   16'(bif.fBank),   16'd5);
    check("wrcm_pending", 16'(bif.pending), 16'h0);
    cyc(0, 1, 12'd5, 16'h0, 0, 16'h0, 0, 0, 0);
    check("rd_other_ack",  16'(bif.ack), 16'h1);
    check("rd_other_data", bif.rdData,   16'h0000);
    cyc(1, 1, 12'd4, 16'h7800, 0, 16'h0, 0, 0, 0);
    check("wr_rd_prewrite", bif.rdData, 16'h2800);
    cyc(0, 1, 12'd4, 16'h0, 0, 16'h0, 0, 0, 0);
    check("wr_rd_after", bif.rdData, 16'h7800);

    cyc(0, 0, 12'd0, 16'h0, 1, 16'h0040, 0, 0, 0);
    check("chan_noack", 16'(bif.ack), 16'h0);
    cyc(0, 0, 12'd0, 16'h0, 0, 16'h0, 1, 0, 0);
    check("chan_super", 16'(bif.superBank), 16'(sb_on));

    cyc(1, 0, 12'd6, 16'h4802, 0, 16'h0, 1, 0, 0);
    check("pre_int_eBank", 16'(bif.eBank), 16'd2);
    check("pre_int_fBank", 16'(bif.fBank), 16'd9);
    cyc(0, 0, 12'd0, 16'h0, 0, 16'h0, 0, 1, 0);
    cyc(1, 0, 12'd6, 16'h0804, 0, 16'h0, 1, 0, 0);
    check("isr_eBank", 16'(bif.eBank), 16'd4);
    check("isr_fBank", 16'(bif.fBank), 16'd1);
    cyc(1, 0, 12'd4, 16'h0800, 0, 16'h0, 0, 0, 1);
    check("resume_eBank",   16'(bif.eBank),   16'd2);
    check("resume_fBank",   16'(bif.fBank),   16'd9);
    check("resume_pending", 16'(bif.pending), 16'h0);
    cyc(0, 1, 12'd4, 16'h0, 0, 16'h0, 0, 0, 0);
    check("resume_rd_fb", bif.rdData, 16'h4800);

    cyc(1, 0, 12'd4, 16'h1800, 0, 16'h0, 0, 0, 0);
    check("stage_pending", 16'(bif.pending), 16'h1);
    @(negedge clk);
    bif.rdEn = 1; bif.regAddr = 12'd4; bif.commit = 1;
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_eBank",   16'(bif.eBank),     16'h0);
    check("arst_fBank",   16'(bif.fBank),     16'h0);
    check("arst_super",   16'(bif.superBank), 16'h0);
    check("arst_pending", 16'(bif.pending),   16'h0);
    check("arst_ack",     16'(bif.ack),       16'h0);
    check("arst_rdData",  bif.rdData,         16'h0);
    drive_idle();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 1, 12'd4, 16'h0, 0, 16'h0, 0, 0, 0);
    check("post_rst_rd_fb", bif.rdData, 16'h0000);
    check("post_rst_ack",   16'(bif.ack), 16'h1);
    idle_cyc();

    for (int i = 0; i < 3000; i++) begin
      logic [11:0] a;
      int pick;
      pick = $urandom_range(0, 4);
      case (pick)
        0: a = 12'd3;
        1: a = 12'd4;
        2: a = 12'd6;
        3: a = 12'd5;
        default: a = 12'($urandom);
      endcase
      cyc(($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0), a, 16'($urandom),
          ($urandom_range(0, 4) == 0), 16'($urandom),
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
    end
    idle_cyc();
    idle_cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
